// File: rtl/popcount_accumulator.sv
// XNOR-popcount accumulator for a 10-neuron binarized layer; one image = NUM_BEATS beats.
// Define POPCOUNT_HOLD_EN to keep final counts on the outputs between images.
module popcount_accumulator #(
  parameter int unsigned BEAT_W    = 16,
  parameter int unsigned NUM_BEATS = 25
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 act_valid,
  output logic                 act_ready,
  input  logic [BEAT_W-1:0]    act_data,
  input  logic [10*BEAT_W-1:0] weight_data,
  output logic [8:0]           popcount_out_1,
  output logic [8:0]           popcount_out_2,
  output logic [8:0]           popcount_out_3,
  output logic [8:0]           popcount_out_4,
  output logic [8:0]           popcount_out_5,
  output logic [8:0]           popcount_out_6,
  output logic [8:0]           popcount_out_7,
  output logic [8:0]           popcount_out_8,
  output logic [8:0]           popcount_out_9,
  output logic [8:0]           popcount_out_10,
  output logic                 valid_out,
  output logic                 busy
);

  localparam int unsigned NumNeurons = 10;
  localparam int unsigned AccW       = 9;
  localparam int unsigned PcW        = $clog2(BEAT_W + 1);
  localparam int unsigned CntW       = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]                           state_q, state_d;
  logic [CntW-1:0]                      beat_q, beat_d;
  logic [NumNeurons-1:0][AccW-1:0]      acc_q, acc_d;
  logic [NumNeurons-1:0][AccW-1:0]      out_q, out_d;
  logic [NumNeurons-1:0][AccW-1:0]      sum;
  logic                                 beat_fire;
  logic                                 last_beat;

  function automatic logic [PcW-1:0] popcnt(input logic [BEAT_W-1:0] v);
    logic [PcW-1:0] c;
    c = '0;
    for (int i = 0; i < BEAT_W; i++) begin
      c = c + PcW'(v[i]);
    end
    return c;
  endfunction

  assign act_ready = (state_q == StAccum);
  assign busy      = (state_q == StAccum) || (state_q == StDone);
  assign valid_out = (state_q == StDone);
  assign beat_fire = act_valid && act_ready;
  assign last_beat = (beat_q == CntW'(NUM_BEATS - 1));

  // Running sum including the beat currently on the bus.
  always_comb begin
    sum = '0;
    for (int n = 0; n < NumNeurons; n++) begin
      sum[n] = acc_q[n] + AccW'(popcnt(~(act_data ^ weight_data[n*BEAT_W +: BEAT_W])));
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    acc_d   = acc_q;
    out_d   = out_q;
`ifndef POPCOUNT_HOLD_EN
    // Outputs are only meaningful during the valid pulse.
    if (state_q == StDone) begin
      out_d = '0;
    end
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          acc_d   = '0;
          beat_d  = '0;
          state_d = StAccum;
        end
      end
      StAccum: begin
        if (beat_fire) begin
          acc_d = sum;
          if (last_beat) begin
            out_d   = sum;
            state_d = StDone;
          end else begin
            beat_d = beat_q + CntW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      beat_q  <= '0;
      acc_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
    end
  end

  assign popcount_out_1  = out_q[0];
  assign popcount_out_2  = out_q[1];
  assign popcount_out_3  = out_q[2];
  assign popcount_out_4  = out_q[3];
  assign popcount_out_5  = out_q[4];
  assign popcount_out_6  = out_q[5];
  assign popcount_out_7  = out_q[6];
  assign popcount_out_8  = out_q[7];
  assign popcount_out_9  = out_q[8];
  assign popcount_out_10 = out_q[9];

endmodule

// File: tb/tb_popcount_accumulator.sv
// Scoreboard bench for popcount_accumulator: driver queues expected counts, monitor checks outputs.
module tb_popcount_accumulator;

  localparam int BW = 16;
  localparam int NB = 25;

  typedef logic [9:0][8:0] exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              act_valid = 1'b0;
  logic [BW-1:0]     act_data = '0;
  logic [10*BW-1:0]  weight_data = '0;
  logic              act_ready;
  logic              valid_out;
  logic              busy;
  logic [8:0]        pc [10];

  exp_t sb[$];
  exp_t last_exp = '0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  popcount_accumulator #(
    .BEAT_W    (BW),
    .NUM_BEATS (NB)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .act_valid       (act_valid),
    .act_ready       (act_ready),
    .act_data        (act_data),
    .weight_data     (weight_data),
    .popcount_out_1  (pc[0]),
    .popcount_out_2  (pc[1]),
    .popcount_out_3  (pc[2]),
    .popcount_out_4  (pc[3]),
    .popcount_out_5  (pc[4]),
    .popcount_out_6  (pc[5]),
    .popcount_out_7  (pc[6]),
    .popcount_out_8  (pc[7]),
    .popcount_out_9  (pc[8]),
    .popcount_out_10 (pc[9]),
    .valid_out       (valid_out),
    .busy            (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [10*BW-1:0] mk_w(input logic [BW-1:0] others, input int sel,
                                            input logic [BW-1:0] selw);
    logic [10*BW-1:0] w;
    for (int n = 0; n < 10; n++) begin
      w[n*BW +: BW] = (n == sel) ? selw : others;
    end
    return w;
  endfunction

  function automatic exp_t one_exp(input int sel, input logic [8:0] v, input logic [8:0] rest);
    exp_t e;
    for (int n = 0; n < 10; n++) begin
      e[n] = (n == sel) ? v : rest;
    end
    return e;
  endfunction

  // Monitor: pop on valid_out, otherwise outputs must be held (or zero).
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      last_exp = '0;
    end
    if (valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid_out 1 expected no result at %0t", $time);
      end else begin
        e = sb.pop_front();
        for (int n = 0; n < 10; n++) begin
          chk($sformatf("result_pc%0d", n + 1), 32'(pc[n]), 32'(e[n]));
        end
        last_exp = e;
      end
    end else begin
`ifdef POPCOUNT_HOLD_EN
      e = last_exp;
`else
      e = '0;
`endif
      for (int n = 0; n < 10; n++) begin
        chk($sformatf("between_pc%0d", n + 1), 32'(pc[n]), 32'(e[n]));
      end
    end
  end

  task automatic run_image(input logic [BW-1:0] a, input logic [10*BW-1:0] w, input bit gap,
                           input bit start_mid, input bit hold_valid, input exp_t e);
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_accum", 32'(busy), 32'd1);
    chk("ready_accum", 32'(act_ready), 32'd1);
    for (int i = 0; i < NB; i++) begin
      if (gap) begin
        act_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      act_valid   = 1'b1;
      act_data    = a;
      weight_data = w;
      start       = start_mid && (i == 12);
      @(posedge clk);
      #1;
    end
    start     = 1'b0;
    act_valid = hold_valid;
    chk("latency_valid", 32'(valid_out), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    chk("ready_done", 32'(act_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("valid_fall", 32'(valid_out), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("ready_idle", 32'(act_ready), 32'd0);
    act_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish by 100000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [10*BW-1:0] ramp_w;
    exp_t ramp_e;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(act_ready), 32'd0);
    chk("rst_pc1", 32'(pc[0]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All matches on every neuron.
    run_image(16'hFFFF, mk_w(16'hFFFF, -1, 16'h0000), 1'b0, 1'b0, 1'b0,
              one_exp(-1, 9'd0, 9'd400));
    // No matches anywhere.
    run_image(16'h0000, mk_w(16'hFFFF, -1, 16'h0000), 1'b0, 1'b0, 1'b0,
              one_exp(-1, 9'd0, 9'd0));
    // Neuron 3 weights all zero -> full match only there.
    run_image(16'h0000, mk_w(16'hFFFF, 3, 16'h0000), 1'b0, 1'b0, 1'b0,
              one_exp(3, 9'd400, 9'd0));
    // Back-to-back: neuron 6 then neuron 2 (with gaps, mid-image start, valid held after).
    run_image(16'h00FF, mk_w(16'hFF00, 6, 16'h00FF), 1'b0, 1'b0, 1'b0,
              one_exp(6, 9'd400, 9'd0));
    run_image(16'h00FF, mk_w(16'hFF00, 2, 16'h00FF), 1'b1, 1'b1, 1'b1,
              one_exp(2, 9'd400, 9'd0));
    // A5A5 vs 0F0F: xnor = 5555 -> 8 per beat = 200; neuron 5 exact match = 400.
    run_image(16'hA5A5, mk_w(16'h0F0F, 5, 16'hA5A5), 1'b1, 1'b0, 1'b0,
              one_exp(5, 9'd400, 9'd200));

    // Abort an image after 10 beats with reset; it must leave no trace.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      act_valid   = 1'b1;
      act_data    = 16'hFFFF;
      weight_data = mk_w(16'hFFFF, -1, 16'h0000);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid_out), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_ready", 32'(act_ready), 32'd0);
    chk("midrst_pc3", 32'(pc[2]), 32'd0);
    act_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Neuron n weight has n+1 low ones; act all ones -> 25*(n+1).
    ramp_w = '0;
    for (int n = 0; n < 10; n++) begin
      ramp_w[n*BW +: BW] = BW'((32'd1 << (n + 1)) - 32'd1);
    end
    ramp_e = {9'd250, 9'd225, 9'd200, 9'd175, 9'd150, 9'd125, 9'd100, 9'd75, 9'd50, 9'd25};
    run_image(16'hFFFF, ramp_w, 1'b0, 1'b1, 1'b0, ramp_e);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/popcount_accumulator.md
POPCOUNT_ACCUMULATOR -- requirements
Module: popcount_accumulator

Interface
REQ-001 Parameter: BEAT_W, 16, activation/weight bits per beat per neuron.
REQ-002 Parameter: NUM_BEATS, 25, beats per image (BEAT_W*NUM_BEATS = 400 bits).
REQ-003 Port: clk  input  1  clock, all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: start  input  1  begin new image; sampled only in IDLE.
REQ-006 Port: act_valid  input  1  act_data/weight_data beat valid.
REQ-007 Port: act_ready  output  1  beat accepted when act_valid && act_ready.
REQ-008 Port: act_data  input  BEAT_W  binarized activation bits of current beat.
REQ-009 Port: weight_data  input  10*BEAT_W  weights; slice [n*BEAT_W +: BEAT_W] belongs to neuron n (0..9).
REQ-010 Port: popcount_out_1..popcount_out_10  output  9 each  final match count of neuron 0..9, feeds comparator popcount_in_1..10.
REQ-011 Port: valid_out  output  1  one-cycle pulse, popcount outputs valid; feeds comparator valid_in.
REQ-012 Port: busy  output  1  high in ACCUM and DONE.

Function
REQ-013 FSM states SHALL be IDLE, ACCUM, DONE; reset state IDLE.
REQ-014 IDLE: on start=1 SHALL clear all 10 accumulators and beat counter, go ACCUM next cycle.
REQ-015 act_ready SHALL be 1 only in ACCUM, combinationally from state.
REQ-016 Per accepted beat, accumulator n SHALL add popcount(~(act_data ^ weight slice n)), range 0..BEAT_W.
REQ-017 Accumulators SHALL be 9 bits; max sum 400, no overflow possible at defaults.
REQ-018 Cycles with act_valid=0 in ACCUM SHALL leave accumulators and beat counter unchanged (gaps allowed, unbounded).
REQ-019 On the edge accepting beat NUM_BEATS, SHALL load popcount_out_n with final sum (including that beat), set valid_out=1, go DONE.
REQ-020 DONE: valid_out SHALL fall on next edge and FSM return to IDLE; valid_out high exactly one cycle.
REQ-021 Latency: valid_out high in the cycle immediately after the final beat is accepted.
REQ-022 start in ACCUM or DONE SHALL be ignored; start in same cycle as returning to IDLE is not sampled until in IDLE.
REQ-023 Beat counter SHALL count 0..NUM_BEATS-1, no wrap beyond; no extra beats accepted after final beat.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, beat counter 0, accumulators 0, all popcount_out 0, valid_out 0, act_ready 0, busy 0.
REQ-025 Reset mid-ACCUM SHALL discard partial image; no valid_out produced for it.

Configuration
REQ-026 Macro POPCOUNT_HOLD_EN defined: popcount_out_1..10 SHALL hold last final values until next image completes or reset.
REQ-027 Macro POPCOUNT_HOLD_EN undefined: popcount_out_1..10 SHALL be 0 in every cycle valid_out=0 (nonzero only during the valid pulse).

Verification
REQ-028 All-ones act_data and weights, 25 back-to-back beats -> all popcount_out=400, valid_out one cycle after beat 25.
REQ-029 act_data=0, all weights 16'hFFFF -> all popcount_out=0; weights 16'h0000 for neuron 3 only -> popcount_out_4=400, others 0.
REQ-030 act_data=16'h00FF, neuron n weights=16'h00FF, others 16'hFF00 -> popcount_out_(n+1)=400, others 0; act_valid toggled every other cycle -> same values, valid_out after 25th accepted beat.
REQ-031 rst_n pulsed low after beat 10 -> outputs 0, IDLE; new start + 25 beats -> correct counts, no stale contribution.
REQ-032 start pulsed during ACCUM -> ignored, counts unaffected; act_valid held high in DONE/IDLE -> act_ready=0, no accumulation.
REQ-033 Two images back-to-back: cycle after valid_out, popcount_out = image-1 values with POPCOUNT_HOLD_EN, 0 without.
